// File: rtl/jt12_slotreg_pkg.sv
// Shared sizing helpers and slot addressing for the jt12_slotreg register file.
package jt12_slotreg_pkg;

    function automatic int unsigned calc_slots(input int unsigned channels, input int unsigned ops);
        return channels * ops;
    endfunction

    function automatic int unsigned calc_cw(input int unsigned channels);
        return $clog2(channels);
    endfunction

    function automatic int unsigned calc_ow(input int unsigned ops);
        return (ops > 1) ? $clog2(ops) : 1;
    endfunction

    function automatic int unsigned calc_sw(input int unsigned channels, input int unsigned ops);
        return $clog2(channels * ops);
    endfunction

    // Operators of one channel sit CHANNELS slots apart.
    function automatic int unsigned slot_of(input int unsigned ch, input int unsigned op,
                                            input int unsigned channels);
        return op * channels + ch;
    endfunction

endpackage

// File: rtl/jt12_slotreg_ring.sv
// Circular shift storage: head re-enters the tail each clock, optionally merged under a mask.
module jt12_slotreg_ring #(
    parameter int unsigned DEPTH = 24,
    parameter int unsigned WIDTH = 44
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             merge_en,
    input  logic [WIDTH-1:0] merge_data,
    input  logic [WIDTH-1:0] merge_mask,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] entry
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        entry = merge_en ? ((mem_q[0] & ~merge_mask) | (merge_data & merge_mask)) : mem_q[0];
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            mem_d[i] = mem_q[i + 1];
        end
        mem_d[DEPTH-1] = entry;
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rst) begin
                mem_q[i] <= '0;
            end else begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign head = mem_q[0];

endmodule

// File: rtl/jt12_slotreg.sv
// Time-multiplexed operator/channel register file with masked commits and readback.
module jt12_slotreg
    import jt12_slotreg_pkg::*;
#(
    parameter int unsigned CHANNELS = 6,
    parameter int unsigned OPS      = 4,
    parameter int unsigned OPW      = 44,
    parameter int unsigned CHW      = 27,
    localparam int unsigned SLOTS   = calc_slots(CHANNELS, OPS),
    localparam int unsigned CW      = calc_cw(CHANNELS),
    localparam int unsigned OW      = calc_ow(OPS),
    localparam int unsigned SW      = calc_sw(CHANNELS, OPS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_op_req,
    input  logic [CW-1:0]  wr_ch,
    input  logic [OW-1:0]  wr_op,
    input  logic [OPW-1:0] wr_op_data,
    input  logic [OPW-1:0] wr_op_mask,
    input  logic           wr_ch_req,
    input  logic [CHW-1:0] wr_ch_data,
    input  logic [CHW-1:0] wr_ch_mask,
    input  logic           rd_req,
    output logic           busy,
    output logic           wr_err,
    output logic           rd_valid,
    output logic [OPW-1:0] rd_op_word,
    output logic [CHW-1:0] rd_ch_word,
    output logic [OPW-1:0] op_word,
    output logic [CHW-1:0] ch_word,
    output logic [SW-1:0]  cur_slot,
    output logic [CW-1:0]  cur_ch,
    output logic           zero
);

    logic [SW-1:0]  cur_slot_q, cur_slot_d;
    logic [CW-1:0]  cur_ch_q, cur_ch_d;
    logic           zero_q, zero_d;

    logic           pend_op_q, pend_op_d;
    logic [SW-1:0]  op_slot_q, op_slot_d;
    logic [OPW-1:0] op_data_q, op_data_d;
    logic [OPW-1:0] op_mask_q, op_mask_d;

    logic           pend_ch_q, pend_ch_d;
    logic [CW-1:0]  ch_tgt_q, ch_tgt_d;
    logic [CHW-1:0] ch_data_q, ch_data_d;
    logic [CHW-1:0] ch_mask_q, ch_mask_d;

    logic           pend_rd_q, pend_rd_d;
    logic [SW-1:0]  rd_slot_q, rd_slot_d;
    logic           rd_valid_q, rd_valid_d;
    logic [OPW-1:0] rd_op_q, rd_op_d;
    logic [CHW-1:0] rd_ch_q, rd_ch_d;
    logic           wr_err_q, wr_err_d;

    logic           ch_ok, op_acc, ch_acc, rd_acc, op_hit, ch_hit, rd_hit;
    logic [SW-1:0]  req_slot;
    logic [OPW-1:0] op_head, op_entry;
    logic [CHW-1:0] ch_head, ch_entry;

    jt12_slotreg_ring #(.DEPTH(SLOTS), .WIDTH(OPW)) u_op_ring (
        .clk        (clk),
        .rst        (rst),
        .merge_en   (op_hit),
        .merge_data (op_data_q),
        .merge_mask (op_mask_q),
        .head       (op_head),
        .entry      (op_entry)
    );

    jt12_slotreg_ring #(.DEPTH(CHANNELS), .WIDTH(CHW)) u_ch_ring (
        .clk        (clk),
        .rst        (rst),
        .merge_en   (ch_hit),
        .merge_data (ch_data_q),
        .merge_mask (ch_mask_q),
        .head       (ch_head),
        .entry      (ch_entry)
    );

    always_comb begin
        ch_ok    = 32'(wr_ch) < CHANNELS;
        req_slot = SW'(slot_of(32'(wr_ch), 32'(wr_op), CHANNELS));

        // Acceptance looks only at registered pending flags, so a target equal to
        // the current head is first reached one full rotation later.
        op_acc = wr_op_req && !pend_op_q && ch_ok;
        ch_acc = wr_ch_req && !pend_ch_q && ch_ok;
        rd_acc = rd_req && !pend_rd_q && ch_ok;
        op_hit = pend_op_q && (cur_slot_q == op_slot_q);
        ch_hit = pend_ch_q && (cur_ch_q == ch_tgt_q);
        rd_hit = pend_rd_q && (cur_slot_q == rd_slot_q);

        cur_slot_d = (cur_slot_q == SW'(SLOTS - 1)) ? '0 : cur_slot_q + SW'(1);
        cur_ch_d   = (cur_ch_q == CW'(CHANNELS - 1)) ? '0 : cur_ch_q + CW'(1);
        zero_d     = (cur_slot_d == '0);

        pend_op_d = op_acc || (pend_op_q && !op_hit);
        op_slot_d = op_acc ? req_slot   : op_slot_q;
        op_data_d = op_acc ? wr_op_data : op_data_q;
        op_mask_d = op_acc ? wr_op_mask : op_mask_q;

        pend_ch_d = ch_acc || (pend_ch_q && !ch_hit);
        ch_tgt_d  = ch_acc ? wr_ch      : ch_tgt_q;
        ch_data_d = ch_acc ? wr_ch_data : ch_data_q;
        ch_mask_d = ch_acc ? wr_ch_mask : ch_mask_q;

        // Capture takes the tail-entry value so a same-cycle commit is visible.
        pend_rd_d  = rd_acc || (pend_rd_q && !rd_hit);
        rd_slot_d  = rd_acc ? req_slot : rd_slot_q;
        rd_valid_d = rd_hit;
        rd_op_d    = rd_hit ? op_entry : rd_op_q;
        rd_ch_d    = rd_hit ? ch_entry : rd_ch_q;

        wr_err_d = (wr_op_req && !op_acc) || (wr_ch_req && !ch_acc) || (rd_req && !rd_acc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_slot_q <= '0;
            cur_ch_q   <= '0;
            zero_q     <= 1'b0;
            pend_op_q  <= 1'b0;
            op_slot_q  <= '0;
            op_data_q  <= '0;
            op_mask_q  <= '0;
            pend_ch_q  <= 1'b0;
            ch_tgt_q   <= '0;
            ch_data_q  <= '0;
            ch_mask_q  <= '0;
            pend_rd_q  <= 1'b0;
            rd_slot_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_op_q    <= '0;
            rd_ch_q    <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            cur_slot_q <= cur_slot_d;
            cur_ch_q   <= cur_ch_d;
            zero_q     <= zero_d;
            pend_op_q  <= pend_op_d;
            op_slot_q  <= op_slot_d;
            op_data_q  <= op_data_d;
            op_mask_q  <= op_mask_d;
            pend_ch_q  <= pend_ch_d;
            ch_tgt_q   <= ch_tgt_d;
            ch_data_q  <= ch_data_d;
            ch_mask_q  <= ch_mask_d;
            pend_rd_q  <= pend_rd_d;
            rd_slot_q  <= rd_slot_d;
            rd_valid_q <= rd_valid_d;
            rd_op_q    <= rd_op_d;
            rd_ch_q    <= rd_ch_d;
            wr_err_q   <= wr_err_d;
        end
    end

    assign busy       = pend_op_q | pend_ch_q;
    assign wr_err     = wr_err_q;
    assign rd_valid   = rd_valid_q;
    assign rd_op_word = rd_op_q;
    assign rd_ch_word = rd_ch_q;
    assign op_word    = op_head;
    assign ch_word    = ch_head;
    assign cur_slot   = cur_slot_q;
    assign cur_ch     = cur_ch_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_jt12_slotreg.sv
// Randomised bench for jt12_slotreg against a due-cycle reference model; also a 3x2 instance.
module tb_jt12_slotreg;

    localparam int CH    = 6;
    localparam int NOPS  = 4;
    localparam int SLOTS = CH * NOPS;
    localparam int OPW   = 44;
    localparam int CHW   = 27;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, wr_op_req, wr_ch_req, rd_req;
    logic [2:0]     wr_ch;
    logic [1:0]     wr_op;
    logic [OPW-1:0] wr_op_data, wr_op_mask, rd_op_word, op_word;
    logic [CHW-1:0] wr_ch_data, wr_ch_mask, rd_ch_word, ch_word;
    logic           busy, wr_err, rd_valid, zero;
    logic [4:0]     cur_slot;
    logic [2:0]     cur_ch;

    jt12_slotreg #(.CHANNELS(CH), .OPS(NOPS), .OPW(OPW), .CHW(CHW)) dut (
        .clk(clk), .rst(rst), .wr_op_req(wr_op_req), .wr_ch(wr_ch), .wr_op(wr_op),
        .wr_op_data(wr_op_data), .wr_op_mask(wr_op_mask), .wr_ch_req(wr_ch_req),
        .wr_ch_data(wr_ch_data), .wr_ch_mask(wr_ch_mask), .rd_req(rd_req), .busy(busy),
        .wr_err(wr_err), .rd_valid(rd_valid), .rd_op_word(rd_op_word), .rd_ch_word(rd_ch_word),
        .op_word(op_word), .ch_word(ch_word), .cur_slot(cur_slot), .cur_ch(cur_ch), .zero(zero)
    );

    logic           s_rst, s_wr_op_req, s_wr_ch_req, s_rd_req;
    logic [1:0]     s_wr_ch;
    logic [0:0]     s_wr_op;
    logic [OPW-1:0] s_wr_op_data, s_wr_op_mask, s_rd_op_word, s_op_word;
    logic [CHW-1:0] s_wr_ch_data, s_wr_ch_mask, s_rd_ch_word, s_ch_word;
    logic           s_busy, s_wr_err, s_rd_valid, s_zero;
    logic [2:0]     s_cur_slot;
    logic [1:0]     s_cur_ch;

    jt12_slotreg #(.CHANNELS(3), .OPS(2), .OPW(OPW), .CHW(CHW)) dut_s (
        .clk(clk), .rst(s_rst), .wr_op_req(s_wr_op_req), .wr_ch(s_wr_ch), .wr_op(s_wr_op),
        .wr_op_data(s_wr_op_data), .wr_op_mask(s_wr_op_mask), .wr_ch_req(s_wr_ch_req),
        .wr_ch_data(s_wr_ch_data), .wr_ch_mask(s_wr_ch_mask), .rd_req(s_rd_req), .busy(s_busy),
        .wr_err(s_wr_err), .rd_valid(s_rd_valid), .rd_op_word(s_rd_op_word),
        .rd_ch_word(s_rd_ch_word), .op_word(s_op_word), .ch_word(s_ch_word),
        .cur_slot(s_cur_slot), .cur_ch(s_cur_ch), .zero(s_zero)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: storage arrays plus, per pending request, the cycle it lands.
    logic [OPW-1:0] m_op [SLOTS];
    logic [CHW-1:0] m_ch [CH];
    int             m_cyc;
    bit             m_pop, m_pch, m_prd, m_err, m_rv;
    int             m_pop_due, m_pch_due, m_prd_due, m_pop_t, m_pch_t, m_prd_t;
    logic [OPW-1:0] m_pop_data, m_pop_mask, m_rop;
    logic [CHW-1:0] m_pch_data, m_pch_mask, m_rch;

    task automatic model_reset();
        for (int i = 0; i < SLOTS; i++) m_op[i] = '0;
        for (int i = 0; i < CH; i++) m_ch[i] = '0;
        m_cyc = 0; m_pop = 0; m_pch = 0; m_prd = 0; m_err = 0; m_rv = 0;
        m_rop = '0; m_rch = '0;
    endtask

    task automatic model_edge();
        int s, c, t;
        bit pop0, pch0, prd0, e, rv;
        s = m_cyc % SLOTS; c = m_cyc % CH;
        pop0 = m_pop; pch0 = m_pch; prd0 = m_prd; e = 0; rv = 0;
        if (pop0 && m_pop_due == m_cyc) begin
            m_op[m_pop_t] = (m_op[m_pop_t] & ~m_pop_mask) | (m_pop_data & m_pop_mask);
            m_pop = 0;
        end
        if (pch0 && m_pch_due == m_cyc) begin
            m_ch[m_pch_t] = (m_ch[m_pch_t] & ~m_pch_mask) | (m_pch_data & m_pch_mask);
            m_pch = 0;
        end
        if (prd0 && m_prd_due == m_cyc) begin
            m_rop = m_op[m_prd_t]; m_rch = m_ch[m_prd_t % CH]; rv = 1; m_prd = 0;
        end
        if (wr_op_req) begin
            if (!pop0 && int'(wr_ch) < CH) begin
                t = int'(wr_op) * CH + int'(wr_ch);
                m_pop = 1; m_pop_t = t; m_pop_data = wr_op_data; m_pop_mask = wr_op_mask;
                m_pop_due = m_cyc + ((t - s + SLOTS - 1) % SLOTS) + 1;
            end else e = 1;
        end
        if (wr_ch_req) begin
            if (!pch0 && int'(wr_ch) < CH) begin
                t = int'(wr_ch);
                m_pch = 1; m_pch_t = t; m_pch_data = wr_ch_data; m_pch_mask = wr_ch_mask;
                m_pch_due = m_cyc + ((t - c + CH - 1) % CH) + 1;
            end else e = 1;
        end
        if (rd_req) begin
            if (!prd0 && int'(wr_ch) < CH) begin
                t = int'(wr_op) * CH + int'(wr_ch);
                m_prd = 1; m_prd_t = t;
                m_prd_due = m_cyc + ((t - s + SLOTS - 1) % SLOTS) + 1;
            end else e = 1;
        end
        m_err = e; m_rv = rv; m_cyc++;
    endtask

    task automatic tick();
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_op_req = 0; wr_ch_req = 0; rd_req = 0;
    endtask

    task automatic rand_words();
        logic [63:0] r;
        r = {$urandom, $urandom}; wr_op_data = r[OPW-1:0];
        r = {$urandom, $urandom}; wr_op_mask = r[OPW-1:0];
        r = {$urandom, $urandom}; wr_ch_data = r[CHW-1:0];
        r = {$urandom, $urandom}; wr_ch_mask = r[CHW-1:0];
    endtask

    task automatic test_reset();
        n_checks++; if (cur_slot !== 5'd0) begin n_fail++; $display("FAIL reset_slot: got %0d want 0", cur_slot); end
        n_checks++; if (cur_ch !== 3'd0) begin n_fail++; $display("FAIL reset_ch: got %0d want 0", cur_ch); end
        n_checks++; if ({zero, busy, wr_err, rd_valid} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {zero, busy, wr_err, rd_valid}); end
        n_checks++; if (op_word !== '0 || ch_word !== '0) begin n_fail++; $display("FAIL reset_words: got %0h/%0h want 0", op_word, ch_word); end
        n_checks++; if (rd_op_word !== '0 || rd_ch_word !== '0) begin n_fail++; $display("FAIL reset_rd: got %0h/%0h want 0", rd_op_word, rd_ch_word); end
    endtask

    task automatic test_sequence();
        for (int k = 0; k < 48; k++) begin
            tick();
            n_checks++; if (int'(cur_slot) != m_cyc % SLOTS) begin n_fail++; $display("FAIL seq_slot: got %0d want %0d", cur_slot, m_cyc % SLOTS); end
            n_checks++; if (int'(cur_ch) != m_cyc % CH) begin n_fail++; $display("FAIL seq_ch: got %0d want %0d", cur_ch, m_cyc % CH); end
            n_checks++; if (zero !== (m_cyc % SLOTS == 0)) begin n_fail++; $display("FAIL seq_zero: got %b at slot %0d", zero, cur_slot); end
            n_checks++; if (op_word !== '0 || ch_word !== '0) begin n_fail++; $display("FAIL seq_words: got %0h/%0h want 0", op_word, ch_word); end
        end
    endtask

    task automatic test_op_write();
        int busy_cnt = 0;
        while (m_cyc % SLOTS != 5) tick();
        wr_op_req = 1; wr_ch = 3'd2; wr_op = 2'd3; wr_op_data = '1; wr_op_mask = 44'hFF;
        tick(); idle();
        for (int k = 0; k < 30; k++) begin
            if (busy) busy_cnt++;
            n_checks++; if (op_word !== m_op[m_cyc % SLOTS]) begin n_fail++; $display("FAIL opw_word: got %0h want %0h", op_word, m_op[m_cyc % SLOTS]); end
            tick();
        end
        n_checks++; if (busy_cnt != 15) begin n_fail++; $display("FAIL opw_busy_len: got %0d want 15", busy_cnt); end
        for (int k = 0; k < SLOTS; k++) begin
            n_checks++; if (op_word !== ((m_cyc % SLOTS == 20) ? 44'hFF : 44'h0)) begin n_fail++; $display("FAIL opw_slot20: got %0h at slot %0d", op_word, cur_slot); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        while (m_cyc % SLOTS != 0) tick();
        rand_words();
        wr_op_req = 1; wr_ch_req = 1; wr_ch = 3'd4; wr_op = 2'd2;
        tick(); idle();
        rand_words();
        wr_op_req = 1; wr_ch = 3'd1; wr_op = 2'd0;
        tick(); idle();
        n_checks++; if (wr_err !== 1'b1) begin n_fail++; $display("FAIL b2b_err: got %b want 1", wr_err); end
        for (int k = 0; k < 2 * SLOTS; k++) begin
            n_checks++; if (op_word !== m_op[m_cyc % SLOTS] || ch_word !== m_ch[m_cyc % CH]) begin n_fail++; $display("FAIL b2b_words: got %0h/%0h want %0h/%0h", op_word, ch_word, m_op[m_cyc % SLOTS], m_ch[m_cyc % CH]); end
            n_checks++; if (busy !== (m_pop | m_pch) || wr_err !== m_err) begin n_fail++; $display("FAIL b2b_flags: got %b%b want %b%b", busy, wr_err, m_pop | m_pch, m_err); end
            tick();
        end
    endtask

    task automatic test_invalid();
        for (int k = 0; k < 2 * SLOTS && (m_pop || m_pch || m_prd); k++) tick();
        wr_op_req = 1; wr_ch = 3'd6; wr_op = 2'd1; rand_words();
        tick(); idle();
        n_checks++; if (wr_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL inv_op: got err=%b busy=%b want 1/0", wr_err, busy); end
        tick();
        n_checks++; if (wr_err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL inv_after: got err=%b busy=%b want 0/0", wr_err, busy); end
        wr_ch_req = 1; rd_req = 1; wr_ch = 3'd7;
        tick(); idle();
        n_checks++; if (wr_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL inv_ch_rd: got err=%b busy=%b want 1/0", wr_err, busy); end
        for (int k = 0; k < SLOTS + 2; k++) begin
            n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL inv_rdv: got %b want 0", rd_valid); end
            tick();
        end
    endtask

    task automatic test_read_merge();
        int ch, op, t, waited;
        logic [OPW-1:0] exp_op;
        logic [CHW-1:0] exp_ch;
        while (m_cyc % SLOTS != 0) tick();
        ch = $urandom_range(0, CH - 1); op = $urandom_range(1, NOPS - 1); t = op * CH + ch;
        rand_words();
        exp_op = (m_op[t] & ~wr_op_mask) | (wr_op_data & wr_op_mask);
        exp_ch = (m_ch[ch] & ~wr_ch_mask) | (wr_ch_data & wr_ch_mask);
        wr_op_req = 1; wr_ch_req = 1; wr_ch = 3'(ch); wr_op = 2'(op);
        tick(); idle();
        rd_req = 1;
        tick(); idle();
        waited = 0;
        while (rd_valid !== 1'b1 && waited < SLOTS + 2) begin tick(); waited++; end
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL rdm_timeout: rd_valid never seen in %0d cycles", waited); end
        n_checks++; if (rd_op_word !== exp_op) begin n_fail++; $display("FAIL rdm_op: got %0h want %0h", rd_op_word, exp_op); end
        n_checks++; if (rd_ch_word !== exp_ch) begin n_fail++; $display("FAIL rdm_ch: got %0h want %0h", rd_ch_word, exp_ch); end
        tick();
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rdm_pulse: got %b want 0", rd_valid); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            wr_op_req = ($urandom_range(0, 3) == 0);
            wr_ch_req = ($urandom_range(0, 3) == 0);
            rd_req    = ($urandom_range(0, 5) == 0);
            wr_ch = 3'($urandom_range(0, 7)); wr_op = 2'($urandom_range(0, 3));
            rand_words();
            case ($urandom_range(0, 3))
                0: begin wr_op_mask = '0; wr_ch_mask = '0; end
                1: begin wr_op_mask = '1; wr_ch_mask = '1; end
                default: ;
            endcase
            tick(); idle();
            n_checks++; if (op_word !== m_op[m_cyc % SLOTS] || ch_word !== m_ch[m_cyc % CH]) begin n_fail++; $display("FAIL rnd_words: got %0h/%0h want %0h/%0h", op_word, ch_word, m_op[m_cyc % SLOTS], m_ch[m_cyc % CH]); end
            n_checks++; if ({busy, wr_err, rd_valid} !== {m_pop | m_pch, m_err, m_rv}) begin n_fail++; $display("FAIL rnd_flags: got %b want %b", {busy, wr_err, rd_valid}, {m_pop | m_pch, m_err, m_rv}); end
            n_checks++; if (rd_op_word !== m_rop || rd_ch_word !== m_rch) begin n_fail++; $display("FAIL rnd_rd: got %0h/%0h want %0h/%0h", rd_op_word, rd_ch_word, m_rop, m_rch); end
        end
    endtask

    task automatic test_reset_mid();
        while (m_pop || m_pch || m_prd) tick();
        while (m_cyc % SLOTS != 0) tick();
        rand_words(); wr_op_mask = '1; wr_ch_mask = '1;
        wr_op_req = 1; wr_ch_req = 1; rd_req = 1; wr_ch = 3'd5; wr_op = 2'd3;
        tick(); idle();
        tick(); tick();
        rst = 1; @(negedge clk); rst = 0; model_reset();
        for (int k = 0; k < 2 * SLOTS; k++) begin
            n_checks++; if (op_word !== '0 || ch_word !== '0 || busy !== 1'b0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid: got %0h/%0h busy=%b rdv=%b want 0", op_word, ch_word, busy, rd_valid); end
            n_checks++; if (int'(cur_slot) != m_cyc % SLOTS) begin n_fail++; $display("FAIL rstmid_slot: got %0d want %0d", cur_slot, m_cyc % SLOTS); end
            tick();
        end
    endtask

    task automatic test_small();
        s_rst = 1; @(negedge clk); s_rst = 0;
        n_checks++; if (s_cur_slot !== 3'd0 || s_zero !== 1'b0) begin n_fail++; $display("FAIL sm_reset: got slot=%0d zero=%b want 0/0", s_cur_slot, s_zero); end
        s_wr_op_req = 1; s_wr_ch_req = 1; s_wr_ch = 2'd2; s_wr_op = 1'b1;
        s_wr_op_data = '1; s_wr_op_mask = '1; s_wr_ch_data = '1; s_wr_ch_mask = '1;
        @(negedge clk); s_wr_op_req = 0; s_wr_ch_req = 0;
        n_checks++; if (s_busy !== 1'b1) begin n_fail++; $display("FAIL sm_busy: got %b want 1", s_busy); end
        @(negedge clk); s_rst = 1; @(negedge clk); s_rst = 0;
        for (int k = 0; k < 18; k++) begin
            n_checks++; if (s_cur_slot !== 3'(k % 6) || s_cur_ch !== 2'(k % 3)) begin n_fail++; $display("FAIL sm_seq: got %0d/%0d want %0d/%0d", s_cur_slot, s_cur_ch, k % 6, k % 3); end
            n_checks++; if (s_zero !== (k > 0 && k % 6 == 0)) begin n_fail++; $display("FAIL sm_zero: got %b at k=%0d", s_zero, k); end
            n_checks++; if (s_op_word !== '0 || s_ch_word !== '0 || s_busy !== 1'b0) begin n_fail++; $display("FAIL sm_nocommit: got %0h/%0h busy=%b want 0", s_op_word, s_ch_word, s_busy); end
            @(negedge clk);
        end
    endtask

    initial begin
        idle(); wr_ch = '0; wr_op = '0; rand_words();
        s_wr_op_req = 0; s_wr_ch_req = 0; s_rd_req = 0; s_wr_ch = '0; s_wr_op = '0;
        s_wr_op_data = '0; s_wr_op_mask = '0; s_wr_ch_data = '0; s_wr_ch_mask = '0;
        rst = 1; s_rst = 1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        test_reset();
        test_sequence();
        test_op_write();
        test_back_to_back();
        test_invalid();
        test_read_merge();
        test_random();
        test_reset_mid();
        test_small();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
